operand_ring_queue: RTL and testbench
=====================================

Name: operand_ring_queue

Overview:
Parametrised successor to the calculator's fixed 5x8 operand queue. It is a circular buffer with head and tail pointers and a valid/ready command handshake. Supported operations are push, pop-one, pop-pair and pop+push-result, and the block reports occupancy and errors. It sits between the expression decoder (the command source) and the ALU, which consumes the concatenated top operands.

Parameters:
DATA_W, 8, operand width in bits (>=1)
DEPTH, 8, number of entries (>=2; need not be a power of two)
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, localparam)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
op_valid  in  1  command valid
op_ready  out  1  command ready
opcode  in  2  00 PUSH, 01 POP1_PUSH, 10 POP2_PUSH, 11 POP1
back  in  DATA_W  operand appended at the tail for PUSH, POP1_PUSH and POP2_PUSH
flush  in  1  synchronous clear of queue contents
err_clr  in  1  clears the sticky error flags
top_conc  out  2*DATA_W  popped data: {first, second}, or {first, 0}
top_valid  out  1  one-cycle pulse, top_conc updated this cycle
count  out  CNT_W  current occupancy
empty  out  1  count==0
full  out  1  count==DEPTH
err_underflow  out  1  sticky: pop attempted with insufficient entries
err_overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset (rst_n low, asynchronous): head=tail=0, count=0, top_conc=0, top_valid=0, both error flags 0, storage contents don't-care. A reset asserted mid-command aborts that command; no partial update survives.
- op_ready = rst_n-synchronised high and !flush. A command is accepted when op_valid && op_ready. Commands never stall otherwise.
- Single-state datapath; every accepted command completes in 1 cycle. Results are registered: top_conc and top_valid appear on the cycle after acceptance (latency 1).
- Read-before-write semantics: pops read the pre-edge head entries. The write at the tail uses the pre-edge tail.
- PUSH:
  - legal if count<DEPTH: mem[tail]<=back, tail++, count+1.
  - full: command dropped, err_overflow<=1, no state change.
  - top_valid=0, top_conc holds.
- POP1: requires count>=1. top_conc<={mem[head], DATA_W'0}, head++, count-1, top_valid=1.
- POP1_PUSH: requires count>=1. Pop as POP1, push back. Net count unchanged, so it is legal when full. With count==1, the queue ends holding only back.
- POP2_PUSH: requires count>=2. top_conc<={mem[head], mem[head+1]}, head+=2, push back, count-1.
- Underflow (any pop with insufficient count): the whole command is dropped, including its push. err_underflow<=1, top_valid=0.
- Pointer wrap: increment yields 0 after DEPTH-1. A +2 step wraps modulo DEPTH (DEPTH-1 -> 1, DEPTH-2 -> 0).
- flush (priority below reset, above commands): head=tail=count=0, top_valid=0. top_conc and error flags hold.
- err_clr clears both sticky flags. If an error occurs in the same cycle as err_clr, set wins.
- Dropped/illegal commands still count as accepted (handshake completes); only the flags record them.
- top_valid deasserts the cycle after any accepted pop unless another pop is accepted.

Decomposition:
- Package operand_queue_pkg: opcode localparams OP_PUSH/OP_POP1_PUSH/OP_POP2_PUSH/OP_POP1 and the pointer-width function.
- One sub-module, ring_ptr_step: a combinational modulo-DEPTH adder (ptr, step 0..2) -> next ptr. It is instantiated for the head, for head+1 and for the tail.

Test Plan:
- Reset then 3x PUSH 0x11,0x22,0x33 -> count=3, empty=0; POP2_PUSH back=0x44 -> next cycle top_conc=0x1122, top_valid=1, count=2.
- DEPTH=8: 8 PUSHes then PUSH 0x99 -> full=1, err_overflow=1, count stays 8; POP1_PUSH back=0xAA -> top_conc=first<<8, count=8, no overflow set.
- Empty queue, POP1 -> err_underflow=1, top_valid=0, count=0; count=1, POP2_PUSH back=0x55 -> dropped, count=1, err_underflow=1.
- Wrap: DEPTH=5, head at 4 with count=2 (entries 0xA0 at index 4, 0xB0 at index 0), POP2_PUSH -> top_conc=0xA0B0, head=1.
- rst_n pulsed low asynchronously between clock edges mid-stream -> outputs zero immediately; flush with count=4 -> count=0, top_conc unchanged.
- err_clr coincident with a new overflow -> err_overflow remains 1; err_clr alone next cycle -> 0.

Source files
------------

// File: rtl/operand_ring_queue_pkg.sv
// Shared opcodes and sizing helpers for the operand ring queue.
package operand_queue_pkg;

    localparam logic [1:0] OP_PUSH      = 2'b00;
    localparam logic [1:0] OP_POP1_PUSH = 2'b01;
    localparam logic [1:0] OP_POP2_PUSH = 2'b10;
    localparam logic [1:0] OP_POP1      = 2'b11;

    // Pointer width for a ring of the given depth, never below one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/operand_ring_queue_ptr_step.sv
// Modulo-DEPTH pointer advance by 0, 1 or 2 for non-power-of-two rings.
module ring_ptr_step
    import operand_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = ptr_w(DEPTH)
) (
    input  logic [PW-1:0] ptr,
    input  logic [1:0]    step,
    output logic [PW-1:0] nxt
);

    localparam logic [PW:0] LIM = (PW + 1)'(DEPTH);

    logic [PW:0] sum;
    logic [PW:0] wrapped;

    // ptr < DEPTH and step <= 2 <= DEPTH, so one subtraction suffices.
    assign sum     = {1'b0, ptr} + (PW + 1)'(step);
    assign wrapped = sum - LIM;
    assign nxt     = (sum >= LIM) ? wrapped[PW-1:0] : sum[PW-1:0];

endmodule

// File: rtl/operand_ring_queue.sv
// Circular operand queue between the expression decoder and the ALU.
module operand_ring_queue
    import operand_queue_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [1:0]          opcode,
    input  logic [DATA_W-1:0]   back,
    input  logic                flush,
    input  logic                err_clr,
    output logic [2*DATA_W-1:0] top_conc,
    output logic                top_valid,
    output logic [CNT_W-1:0]    count,
    output logic                empty,
    output logic                full,
    output logic                err_underflow,
    output logic                err_overflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     head_nx;
    logic [PW-1:0]     head_p1;
    logic [PW-1:0]     tail_nx;
    logic [1:0]        sync;
    logic              accept;
    logic              want_push;
    logic              want_pop;
    logic              pop_two;
    logic              short;
    logic              pop_ok;
    logic              push_ok;
    logic              overflow;
    logic              underflow;
    logic [1:0]        pop_step;
    logic [CNT_W-1:0]  need;
    logic [CNT_W-1:0]  count_nx;
    logic [DATA_W-1:0] second;

    assign op_ready = sync[1] & ~flush;
    assign accept   = op_valid & op_ready;
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);

    always_comb begin
        want_push = 1'b0;
        want_pop  = 1'b0;
        pop_two   = 1'b0;
        unique case (opcode)
            OP_PUSH: want_push = 1'b1;
            OP_POP1_PUSH: begin
                want_push = 1'b1;
                want_pop  = 1'b1;
            end
            OP_POP2_PUSH: begin
                want_push = 1'b1;
                want_pop  = 1'b1;
                pop_two   = 1'b1;
            end
            OP_POP1: want_pop = 1'b1;
            default: ;
        endcase
    end

    // A short pop drops the whole command, push included.
    assign need      = pop_two ? CNT_W'(2) : CNT_W'(1);
    assign short     = want_pop & (count < need);
    assign underflow = accept & short;
    assign pop_ok    = accept & want_pop & ~short;
    assign overflow  = accept & want_push & ~want_pop & full;
    assign push_ok   = accept & want_push & ~short
                     & (want_pop | ~full);

    assign pop_step = pop_ok ? (pop_two ? 2'd2 : 2'd1) : 2'd0;
    assign count_nx = count + CNT_W'(push_ok) - CNT_W'(pop_step);
    assign second   = pop_two ? mem[head_p1] : '0;

    ring_ptr_step #(.DEPTH(DEPTH)) u_head (
        .ptr  (head),
        .step (pop_step),
        .nxt  (head_nx)
    );

    ring_ptr_step #(.DEPTH(DEPTH)) u_head_p1 (
        .ptr  (head),
        .step (2'd1),
        .nxt  (head_p1)
    );

    ring_ptr_step #(.DEPTH(DEPTH)) u_tail (
        .ptr  (tail),
        .step ({1'b0, push_ok}),
        .nxt  (tail_nx)
    );

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= back;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync          <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            top_conc      <= '0;
            top_valid     <= 1'b0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            sync <= {sync[0], 1'b1};
            if (flush) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                top_valid <= 1'b0;
            end else begin
                head      <= head_nx;
                tail      <= tail_nx;
                count     <= count_nx;
                top_valid <= pop_ok;
                if (pop_ok) begin
                    top_conc <= {mem[head], second};
                end
            end
            if (underflow) begin
                err_underflow <= 1'b1;
            end else if (err_clr) begin
                err_underflow <= 1'b0;
            end
            if (overflow) begin
                err_overflow <= 1'b1;
            end else if (err_clr) begin
                err_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_ring_queue.sv
// Bench for operand_ring_queue: DEPTH 8 and DEPTH 5 instances against a queue model.
module tb_operand_ring_queue;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       op_valid [2];
    logic [1:0] opcode [2];
    logic [7:0] back [2];
    logic       flush [2];
    logic       err_clr [2];

    logic        rdy0, rdy1, tv0, tv1;
    logic [15:0] top0, top1;
    logic [3:0]  count0;
    logic [2:0]  count1;
    logic        emp0, emp1, ful0, ful1;
    logic        uf0, uf1, of0, of1;

    operand_ring_queue #(.DATA_W(8), .DEPTH(8)) u_d8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid[0]),
        .op_ready      (rdy0),
        .opcode        (opcode[0]),
        .back          (back[0]),
        .flush         (flush[0]),
        .err_clr       (err_clr[0]),
        .top_conc      (top0),
        .top_valid     (tv0),
        .count         (count0),
        .empty         (emp0),
        .full          (ful0),
        .err_underflow (uf0),
        .err_overflow  (of0)
    );

    operand_ring_queue #(.DATA_W(8), .DEPTH(5)) u_d5 (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid[1]),
        .op_ready      (rdy1),
        .opcode        (opcode[1]),
        .back          (back[1]),
        .flush         (flush[1]),
        .err_clr       (err_clr[1]),
        .top_conc      (top1),
        .top_valid     (tv1),
        .count         (count1),
        .empty         (emp1),
        .full          (ful1),
        .err_underflow (uf1),
        .err_overflow  (of1)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // Behavioural model: a plain FIFO of operands per instance.
    logic [7:0]  mq [2][$];
    logic [15:0] m_top [2];
    bit          m_tv [2];
    bit          m_uf [2];
    bit          m_of [2];
    int          m_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                m_top[i] = '0;
                m_tv[i] = 1'b0;
                m_uf[i] = 1'b0;
                m_of[i] = 1'b0;
            end
            m_rdy = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                int d;
                bit acc;
                logic [7:0] a, b;
                d = (i == 0) ? 8 : 5;
                acc = op_valid[i] && (m_rdy >= 2) && !flush[i];
                if (err_clr[i]) begin
                    m_uf[i] = 1'b0;
                    m_of[i] = 1'b0;
                end
                m_tv[i] = 1'b0;
                if (flush[i]) begin
                    mq[i].delete();
                end else if (acc) begin
                    case (opcode[i])
                        2'b00: begin
                            if (mq[i].size() == d) m_of[i] = 1'b1;
                            else mq[i].push_back(back[i]);
                        end
                        2'b01, 2'b11: begin
                            if (mq[i].size() < 1) begin
                                m_uf[i] = 1'b1;
                            end else begin
                                a = mq[i].pop_front();
                                m_top[i] = {a, 8'h00};
                                m_tv[i] = 1'b1;
                                if (opcode[i] == 2'b01)
                                    mq[i].push_back(back[i]);
                            end
                        end
                        default: begin
                            if (mq[i].size() < 2) begin
                                m_uf[i] = 1'b1;
                            end else begin
                                a = mq[i].pop_front();
                                b = mq[i].pop_front();
                                m_top[i] = {a, b};
                                m_tv[i] = 1'b1;
                                mq[i].push_back(back[i]);
                            end
                        end
                    endcase
                end
            end
            if (m_rdy < 2) m_rdy++;
        end
    end

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            check("cnt0", count0, mq[0].size());
            check("emp0", emp0, mq[0].size() == 0);
            check("ful0", ful0, mq[0].size() == 8);
            check("top0", top0, m_top[0]);
            check("tv0", tv0, m_tv[0]);
            check("uf0", uf0, m_uf[0]);
            check("of0", of0, m_of[0]);
            check("rdy0", rdy0, (m_rdy >= 2) && !flush[0]);
            check("cnt1", count1, mq[1].size());
            check("emp1", emp1, mq[1].size() == 0);
            check("ful1", ful1, mq[1].size() == 5);
            check("top1", top1, m_top[1]);
            check("tv1", tv1, m_tv[1]);
            check("uf1", uf1, m_uf[1]);
            check("of1", of1, m_of[1]);
            check("rdy1", rdy1, (m_rdy >= 2) && !flush[1]);
        end
    end

    task automatic issue(input int i, input logic [1:0] op,
                         input logic [7:0] b);
        op_valid[i] = 1'b1;
        opcode[i] = op;
        back[i] = b;
        @(negedge clk);
        op_valid[i] = 1'b0;
        err_clr[i] = 1'b0;
    endtask

    task automatic do_flush(input int i);
        flush[i] = 1'b1;
        @(negedge clk);
        flush[i] = 1'b0;
    endtask

    task automatic do_clr(input int i);
        err_clr[i] = 1'b1;
        @(negedge clk);
        err_clr[i] = 1'b0;
    endtask

    task automatic start_up();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    logic [1:0] tbl_op [12] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00,
                                2'b00, 2'b10, 2'b01, 2'b10, 2'b11,
                                2'b11, 2'b11};

    initial begin
        for (int i = 0; i < 2; i++) begin
            op_valid[i] = 1'b0;
            opcode[i] = 2'b00;
            back[i] = 8'h00;
            flush[i] = 1'b0;
            err_clr[i] = 1'b0;
        end
        rst_n = 1'b0;
        start_up();
        cmp_en = 1'b1;

        check("reset count", count0, 0);
        check("reset empty", emp0, 1);
        check("reset top", top0, 0);

        issue(0, 2'b00, 8'h11);
        issue(0, 2'b00, 8'h22);
        issue(0, 2'b00, 8'h33);
        check("push3 count", count0, 3);
        check("push3 empty", emp0, 0);
        issue(0, 2'b10, 8'h44);
        check("pop2 top", top0, 16'h1122);
        check("pop2 valid", tv0, 1);
        check("pop2 count", count0, 2);

        issue(0, 2'b00, 8'h55);
        issue(0, 2'b00, 8'h66);
        check("pre flush count", count0, 4);
        do_flush(0);
        check("flush count", count0, 0);
        check("flush top hold", top0, 16'h1122);

        for (int k = 1; k <= 8; k++) issue(0, 2'b00, 8'(k));
        issue(0, 2'b00, 8'h99);
        check("ovf full", ful0, 1);
        check("ovf flag", of0, 1);
        check("ovf count", count0, 8);
        do_clr(0);
        check("clr alone", of0, 0);
        issue(0, 2'b01, 8'hAA);
        check("p1p full top", top0, 16'h0100);
        check("p1p full count", count0, 8);
        check("p1p no ovf", of0, 0);
        err_clr[0] = 1'b1;
        issue(0, 2'b00, 8'h77);
        check("clr vs set", of0, 1);
        do_clr(0);
        check("clr after", of0, 0);

        issue(1, 2'b11, 8'h00);
        check("udf flag", uf1, 1);
        check("udf valid", tv1, 0);
        check("udf count", count1, 0);
        issue(1, 2'b00, 8'h55);
        do_clr(1);
        issue(1, 2'b10, 8'h56);
        check("udf2 count", count1, 1);
        check("udf2 flag", uf1, 1);
        issue(1, 2'b11, 8'h00);
        check("udf2 kept", top1, 16'h5500);

        issue(1, 2'b00, 8'hD1);
        issue(1, 2'b00, 8'hD2);
        issue(1, 2'b00, 8'hD3);
        issue(1, 2'b00, 8'hA0);
        issue(1, 2'b00, 8'hB0);
        check("d5 full", ful1, 1);
        repeat (3) issue(1, 2'b11, 8'h00);
        issue(1, 2'b10, 8'hC0);
        check("wrap top", top1, 16'hA0B0);
        check("wrap count", count1, 1);
        issue(1, 2'b11, 8'h00);
        check("wrap head", top1, 16'hC000);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 12; k++) begin
                issue(1, tbl_op[k], 8'(16 * r + k + 1));
            end
        end

        op_valid[0] = 1'b1;
        opcode[0] = 2'b00;
        back[0] = 8'hEE;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst count", count0, 0);
        check("arst top", top0, 0);
        check("arst flag", of0, 0);
        check("arst empty", emp0, 1);
        check("arst ready", rdy0, 0);
        @(negedge clk);
        op_valid[0] = 1'b0;
        start_up();
        issue(0, 2'b00, 8'h12);
        issue(0, 2'b11, 8'h00);
        check("post rst top", top0, 16'h1200);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
